// File: rtl/lcd_tx_pkg.sv
// Shared definitions for the LCD transmit queue: bus register offsets,
// the queued entry layout, FSM states and the STATUS word packing.
package lcd_tx_pkg;

    localparam logic [3:0] OFFS_DATA   = 4'h0;
    localparam logic [3:0] OFFS_COLOR  = 4'h4;
    localparam logic [3:0] OFFS_FILL   = 4'h8;
    localparam logic [3:0] OFFS_STATUS = 4'hC;

    // One queued item: either a DC-tagged byte or a marker standing in for a fill request.
    typedef struct packed {
        logic       marker;
        logic       dc;
        logic [7:0] dataByte;
    } tx_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        FILL_HI = 2'd2,
        FILL_LO = 2'd3
    } tx_state_t;

    function automatic logic [31:0] packStatus(
        input logic       err,
        input logic       ovf,
        input logic       fillActive,
        input logic       full,
        input logic       empty,
        input logic [6:0] level
    );
        return {20'b0, err, ovf, fillActive, full, empty, level};
    endfunction

endpackage

// File: rtl/lcd_tx_fifo.sv
// Synchronous FIFO with level tracking. The head entry is read straight from
// the registered read pointer, so it is valid in the same cycle as !empty_o.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module lcd_tx_fifo
    import lcd_tx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         pushData_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         headData_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     pushDropped_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [LW-1:0]    level_q;
    logic             doPush;
    logic             doPop;

    assign full_o        = (level_q == LW'(DEPTH));
    assign empty_o       = (level_q == '0);
    assign level_o       = level_q;
    assign doPop         = pop_i && !empty_o;
    assign doPush        = push_i && (!full_o || doPop);
    assign pushDropped_o = push_i && !doPush;
    assign headData_o    = mem[rdPtr_q];

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= pushData_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; level counts 0..DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            if (doPush && !doPop) begin
                level_q <= level_q + LW'(1);
            end else if (doPop && !doPush) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/lcd_tx_queue.sv
// Bus-mapped byte queue feeding the LCD SPI byte engine. The CPU pushes
// DC-tagged bytes and RGB565 rectangle-fill requests; the FSM drains them in
// push order over a registered valid/ready byte handshake.
module lcd_tx_queue
    import lcd_tx_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int FILL_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_dc,
    input  logic        tx_ready,
    output logic        irq_empty
);

    logic [3:0]        offset;
    logic              busWrite;
    logic              busRead;
    logic              wrData;
    logic              wrColor;
    logic              wrFill;
    logic              rdStatus;
    logic [FILL_W-1:0] fillN;
    logic              fillStart;
    logic              fillReject;
    logic              unusedBits;

    logic              pushEn;
    tx_entry_t         pushEntry;
    tx_entry_t         headEntry;
    logic              popEn;
    logic              fillDone;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              pushDropped;
    logic [$clog2(DEPTH):0] fifoLevel;

    logic [15:0]       fillColor_q;
    logic [FILL_W-1:0] fillCount_q;
    logic              fillPending_q;
    logic              err_q;
    logic              ovf_q;

    tx_state_t         state_q,    state_d;
    logic              txValid_q,  txValid_d;
    logic [7:0]        txData_q,   txData_d;
    logic              txDc_q,     txDc_d;
    logic [FILL_W-1:0] pixLeft_q,  pixLeft_d;
    logic [15:0]       col_q,      col_d;

    logic              handshake;
    logic              fillActive;

    assign offset     = address_in[3:0];
    assign busWrite   = sel_in && (|write_mask_in);
    assign busRead    = sel_in && read_in;
    assign wrData     = busWrite && (offset == OFFS_DATA);
    assign wrColor    = busWrite && (offset == OFFS_COLOR);
    assign wrFill     = busWrite && (offset == OFFS_FILL);
    assign rdStatus   = busRead && (offset == OFFS_STATUS);
    assign fillN      = write_value_in[FILL_W-1:0];
    assign fillStart  = wrFill && (fillN != '0) && !fillPending_q;
    assign fillReject = wrFill && (fillN != '0) && fillPending_q;
    assign pushEn     = wrData || fillStart;
    assign unusedBits = ^{address_in[31:4], write_value_in[31:16]};

    assign handshake  = txValid_q && tx_ready;
    assign fillActive = (state_q == FILL_HI) || (state_q == FILL_LO);

    assign ready_out  = sel_in;
    assign tx_valid   = txValid_q;
    assign tx_data    = txData_q;
    assign tx_dc      = txDc_q;
    assign irq_empty  = fifoEmpty && !fillActive && !txValid_q;

    assign read_value_out = (rdStatus && !reset)
        ? packStatus(err_q, ovf_q, fillActive, fifoFull, fifoEmpty, 7'(fifoLevel))
        : 32'h0;

    // Build the entry to queue: a fill request becomes a bare marker, the pixel count lives in fillCount_q.
    always_comb begin
        pushEntry = '0;
        if (wrFill) begin
            pushEntry.marker = 1'b1;
        end else begin
            pushEntry.dc       = write_value_in[8];
            pushEntry.dataByte = write_value_in[7:0];
        end
    end

    lcd_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(tx_entry_t))
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (pushEn),
        .pushData_i    (pushEntry),
        .pop_i         (popEn),
        .headData_o    (headEntry),
        .full_o        (fifoFull),
        .empty_o       (fifoEmpty),
        .level_o       (fifoLevel),
        .pushDropped_o (pushDropped)
    );

    // Bus-side registers; a fill is only armed if its marker actually made it into the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            fillColor_q   <= '0;
            fillCount_q   <= '0;
            fillPending_q <= 1'b0;
            err_q         <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            if (wrColor) begin
                fillColor_q <= write_value_in[15:0];
            end
            if (fillStart && !pushDropped) begin
                fillCount_q   <= fillN;
                fillPending_q <= 1'b1;
            end else if (fillDone) begin
                fillPending_q <= 1'b0;
            end
            if (fillReject) begin
                err_q <= 1'b1;
            end else if (rdStatus) begin
                err_q <= 1'b0;
            end
            if (pushDropped) begin
                ovf_q <= 1'b1;
            end else if (rdStatus) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Next-state and next-output logic; outputs are precomputed so tx_* leave the block registered.
    always_comb begin
        state_d   = state_q;
        txValid_d = txValid_q;
        txData_d  = txData_q;
        txDc_d    = txDc_q;
        pixLeft_d = pixLeft_q;
        col_d     = col_q;
        popEn     = 1'b0;
        fillDone  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    txValid_d = 1'b1;
                    if (headEntry.marker) begin
                        state_d   = FILL_HI;
                        pixLeft_d = fillCount_q;
                        col_d     = fillColor_q;
                        txData_d  = fillColor_q[15:8];
                        txDc_d    = 1'b1;
                    end else begin
                        state_d  = SEND;
                        txData_d = headEntry.dataByte;
                        txDc_d   = headEntry.dc;
                    end
                end
            end
            SEND: begin
                if (handshake) begin
                    popEn     = 1'b1;
                    state_d   = IDLE;
                    txValid_d = 1'b0;
                end
            end
            FILL_HI: begin
                if (handshake) begin
                    state_d  = FILL_LO;
                    txData_d = col_q[7:0];
                    txDc_d   = 1'b1;
                end
            end
            FILL_LO: begin
                if (handshake) begin
                    pixLeft_d = pixLeft_q - FILL_W'(1);
                    if (pixLeft_q == FILL_W'(1)) begin
                        popEn     = 1'b1;
                        fillDone  = 1'b1;
                        state_d   = IDLE;
                        txValid_d = 1'b0;
                    end else begin
                        state_d  = FILL_HI;
                        txData_d = col_q[15:8];
                        txDc_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                txValid_d = 1'b0;
            end
        endcase
    end

    // State and registered handshake outputs; reset drops any byte in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            txValid_q <= 1'b0;
            txData_q  <= '0;
            txDc_q    <= 1'b0;
            pixLeft_q <= '0;
            col_q     <= '0;
        end else begin
            state_q   <= state_d;
            txValid_q <= txValid_d;
            txData_q  <= txData_d;
            txDc_q    <= txDc_d;
            pixLeft_q <= pixLeft_d;
            col_q     <= col_d;
        end
    end

endmodule
